icache_refill_ctrl: RTL

//  Miss/refill sequencer in the IF stage, between the fetch unit, the instruction cache core and the memory bus.

---
 rtl/icache_refill_ctrl_if.sv | 58 +++++
 rtl/icache_refill_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle between the refill controller and its neighbours: the fetch
// unit (request/stall), the instruction cache core (lookup, set valid bits,
// line/tag update) and the memory read bus (request handshake, read beats).
// The master modport belongs to icache_refill_ctrl; the slave modport is
// the environment's view (fetch unit, cache core and memory together).
//   fetch_valid/fetch_addr/fetch_stall              fetch side
//   query_valid/query_addr/query_hit/valid_per_way  cache lookup
//   do_update_line/do_update_tag_and_valid/
//   update_addr/update_way/update_line_data/
//   update_dirty_bit                                cache install
//   mem_req_valid/mem_req_ready/mem_req_addr/
//   mem_rvalid/mem_rdata                            memory read bus
//   miss_count                                      completed refills
interface icache_refill_ctrl_if #(
  parameter int unsigned LINE_SIZE = 64,
  parameter int unsigned WAYS      = 8,
  parameter int unsigned MEM_DW    = 64
);
  localparam int unsigned VW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                     fetch_valid;
  logic [31:0]              fetch_addr;
  logic                     fetch_stall;
  logic                     query_valid;
  logic [31:0]              query_addr;
  logic                     query_hit;
  logic [WAYS-1:0]          valid_per_way;
  logic                     do_update_line;
  logic                     do_update_tag_and_valid;
  logic [31:0]              update_addr;
  logic [VW-1:0]            update_way;
  logic [LINE_SIZE*8-1:0]   update_line_data;
  logic                     update_dirty_bit;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [31:0]              mem_req_addr;
  logic                     mem_rvalid;
  logic [MEM_DW-1:0]        mem_rdata;
  logic [31:0]              miss_count;

  modport master (
    input  fetch_valid, fetch_addr, query_hit, valid_per_way,
           mem_req_ready, mem_rvalid, mem_rdata,
    output fetch_stall, query_valid, query_addr,
           do_update_line, do_update_tag_and_valid, update_addr, update_way,
           update_line_data, update_dirty_bit,
           mem_req_valid, mem_req_addr, miss_count
  );

  modport slave (
    output fetch_valid, fetch_addr, query_hit, valid_per_way,
           mem_req_ready, mem_rvalid, mem_rdata,
    input  fetch_stall, query_valid, query_addr,
           do_update_line, do_update_tag_and_valid, update_addr, update_way,
           update_line_data, update_dirty_bit,
           mem_req_valid, mem_req_addr, miss_count
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer for the IF stage.
// Forwards fetch lookups to the cache; on a miss it stalls fetch, picks a
// victim way (lowest invalid way, else round-robin), bursts the line in from
// memory, installs line + tag/valid in one cycle and replays the lookup.
// Read-only cache: nothing is ever written back.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   flush  pipeline flush, abandons the miss in progress
//   bus    icache_refill_ctrl_if.master (fetch, cache and memory signals)
module icache_refill_ctrl #(
  parameter int unsigned LINE_SIZE = 64,
  parameter int unsigned WAYS      = 8,
  parameter int unsigned MEM_DW    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  icache_refill_ctrl_if.master bus
);
  localparam int unsigned VW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BEATS = LINE_SIZE * 8 / MEM_DW;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_SIZE) - 32'd1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_REPLAY = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [31:0]            miss_addr_q, miss_addr_d;
  logic [VW-1:0]          victim_q, victim_d;
  logic                   from_rr_q, from_rr_d;
  logic [VW-1:0]          rr_q, rr_d;
  logic [BW-1:0]          cnt_q, cnt_d;
  logic [LINE_SIZE*8-1:0] line_q, line_d;
  logic [31:0]            miss_count_q, miss_count_d;

  logic [VW-1:0]          free_way;
  logic                   any_free;
  logic                   last_beat;

  // Lowest-index invalid way of the looked-up set.
  always_comb begin
    free_way = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!bus.valid_per_way[i] && !any_free) begin
        free_way = VW'(i);
        any_free = 1'b1;
      end
    end
  end

  assign last_beat = (cnt_q == BW'(BEATS - 1));

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    victim_d     = victim_q;
    from_rr_d    = from_rr_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    miss_count_d = miss_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fetch_valid && !bus.query_hit && !flush) begin
          miss_addr_d = bus.fetch_addr & LINE_MASK;
          victim_d    = any_free ? free_way : rr_q;
          from_rr_d   = !any_free;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          // Request already accepted: its beats must still be sunk.
          state_d = flush ? S_DRAIN : S_FILL;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (bus.mem_rvalid) begin
          line_d[32'(cnt_q) * MEM_DW +: MEM_DW] = bus.mem_rdata;
          cnt_d = last_beat ? '0 : cnt_q + BW'(1);
        end
        // A flush landing on the final beat has nothing left to drain.
        if (flush) begin
          state_d = (bus.mem_rvalid && last_beat) ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rvalid && last_beat) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        miss_count_d = miss_count_q + 32'd1;
        if (from_rr_q) begin
          rr_d = (rr_q == VW'(WAYS - 1)) ? '0 : rr_q + VW'(1);
        end
        state_d = S_REPLAY;
      end
      S_REPLAY: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.mem_rvalid) begin
          cnt_d = last_beat ? '0 : cnt_q + BW'(1);
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      miss_addr_q  <= '0;
      victim_q     <= '0;
      from_rr_q    <= 1'b0;
      rr_q         <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      victim_q     <= victim_d;
      from_rr_q    <= from_rr_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    bus.fetch_stall             = 1'b0;
    bus.query_valid             = 1'b0;
    bus.query_addr              = '0;
    bus.do_update_line          = 1'b0;
    bus.do_update_tag_and_valid = 1'b0;
    bus.update_addr             = '0;
    bus.update_way              = '0;
    bus.mem_req_valid           = 1'b0;
    bus.mem_req_addr            = '0;
    case (state_q)
      S_IDLE: begin
        bus.query_valid = bus.fetch_valid;
        bus.query_addr  = bus.fetch_addr;
        bus.fetch_stall = bus.fetch_valid & ~bus.query_hit;
      end
      S_REQ: begin
        bus.fetch_stall   = 1'b1;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = miss_addr_q;
      end
      S_UPDATE: begin
        bus.fetch_stall             = 1'b1;
        bus.do_update_line          = 1'b1;
        bus.do_update_tag_and_valid = 1'b1;
        bus.update_addr             = miss_addr_q;
        bus.update_way              = victim_q;
      end
      S_REPLAY: begin
        bus.query_valid = 1'b1;
        bus.query_addr  = bus.fetch_addr;
        bus.fetch_stall = ~bus.query_hit;
      end
      default: begin
        bus.fetch_stall = 1'b1;
      end
    endcase
  end

  assign bus.update_line_data = line_q;
  assign bus.update_dirty_bit = 1'b0;
  assign bus.miss_count       = miss_count_q;
endmodule
